// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler time-sharing one serial Mealy sequence detector among N_REQ requesters.
// Optional hit_mask output when SEQ_DET_HIT_MASK_EN is defined.
module seq_det_scheduler #(
    parameter int N_REQ   = 4,
    parameter int FRAME_W = 16,
    parameter int CNT_W   = $clog2(FRAME_W + 1),
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*FRAME_W-1:0]   frame_data,
    output logic [N_REQ-1:0]           gnt,
    output logic                       busy,
    output logic                       done,
    output logic [ID_W-1:0]            done_id,
    output logic [CNT_W-1:0]           hit_count,
`ifdef SEQ_DET_HIT_MASK_EN
    output logic [FRAME_W-1:0]         hit_mask,
`endif
    output logic                       det_rstn,
    output logic                       det_din,
    input  logic                       det_hit
);
    localparam int IDX_W = $clog2(FRAME_W);

    typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, REPORT} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    sel_id;
    logic [ID_W-1:0]    sel;
    logic               found;
    logic [FRAME_W-1:0] frame;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   bit_idx;
    int unsigned        idx;
`ifdef SEQ_DET_HIT_MASK_EN
    logic [FRAME_W-1:0] mask_acc;
`endif

    // First requesting index at or after rr_ptr, wrapping.
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (rstn && state == IDLE && found)
            gnt[sel] = 1'b1;
    end

    assign busy     = (state != IDLE);
    assign det_rstn = rstn && (state != FLUSH);
    assign det_din  = rstn && (state == SHIFT) && frame[bit_idx];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            sel_id    <= '0;
            frame     <= '0;
            cnt       <= '0;
            bit_idx   <= '0;
            done      <= 1'b0;
            done_id   <= '0;
            hit_count <= '0;
`ifdef SEQ_DET_HIT_MASK_EN
            mask_acc  <= '0;
            hit_mask  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        frame  <= frame_data[sel*FRAME_W +: FRAME_W];
                        sel_id <= sel;
                        rr_ptr <= (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
                        state  <= FLUSH;
                    end
                end
                FLUSH: begin
                    cnt      <= '0;
                    bit_idx  <= IDX_W'(FRAME_W - 1);
`ifdef SEQ_DET_HIT_MASK_EN
                    mask_acc <= '0;
`endif
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (det_hit)
                        cnt <= cnt + 1'b1;
`ifdef SEQ_DET_HIT_MASK_EN
                    mask_acc[bit_idx] <= det_hit;
`endif
                    // Result registers load on the last bit so they are valid alongside done.
                    if (bit_idx == '0) begin
                        state     <= REPORT;
                        done      <= 1'b1;
                        done_id   <= sel_id;
                        hit_count <= cnt + CNT_W'(det_hit);
`ifdef SEQ_DET_HIT_MASK_EN
                        hit_mask  <= mask_acc | FRAME_W'(det_hit);
`endif
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                REPORT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_det_scheduler.sv
// Scoreboard bench for seq_det_scheduler with a behavioural 1011 overlapping Mealy detector.
// Also checks hit_mask when SEQ_DET_HIT_MASK_EN is defined.
module tb_seq_det_scheduler;
    localparam int N_REQ   = 4;
    localparam int FRAME_W = 16;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int ID_W    = $clog2(N_REQ);
    localparam int QD      = 64;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic [N_REQ-1:0]         req = '0;
    logic [N_REQ*FRAME_W-1:0] frame_data = '0;
    logic [N_REQ-1:0]         gnt;
    logic                     busy, done;
    logic [ID_W-1:0]          done_id;
    logic [CNT_W-1:0]         hit_count;
    logic                     det_rstn, det_din, det_hit;
`ifdef SEQ_DET_HIT_MASK_EN
    logic [FRAME_W-1:0]       hit_mask;
`endif

    seq_det_scheduler #(.N_REQ(N_REQ), .FRAME_W(FRAME_W)) dut (
        .clk(clk), .rstn(rstn), .req(req), .frame_data(frame_data),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .hit_count(hit_count),
`ifdef SEQ_DET_HIT_MASK_EN
        .hit_mask(hit_mask),
`endif
        .det_rstn(det_rstn), .det_din(det_din), .det_hit(det_hit)
    );

    always #5 clk = ~clk;

    // Detector: remembers the last three bits since its reset; hit when they read 101 and din is 1.
    logic [2:0] hist = '0;
    int         nbits = 0;
    always @(posedge clk) begin
        if (!det_rstn) begin
            hist  <= '0;
            nbits <= 0;
        end else begin
            hist <= {hist[1:0], det_din};
            if (nbits < 3) nbits <= nbits + 1;
        end
    end
    assign det_hit = det_din && (nbits >= 3) && (hist == 3'b101);

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; int cnt; int mask; int due; } exp_t;
    exp_t sb[$];
    exp_t done_log[$];
    int   gnt_log[$];
    int   gnt_cyc_log[$];

    logic [FRAME_W-1:0] pend [N_REQ][QD];
    int head [N_REQ];
    int tail [N_REQ];
    logic [N_REQ-1:0] gnt_seen = '0;

    int rr_m = 0;
    int next_free = 0;
    int last_g = -100;
    logic [FRAME_W-1:0] cur_f = '0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int ref_count(input logic [FRAME_W-1:0] f);
        int n;
        logic [FRAME_W-1:0] sh;
        n = 0;
        for (int i = 3; i < FRAME_W; i++) begin
            sh = f >> (FRAME_W - 1 - i);
            if (sh[3:0] == 4'b1011) n++;
        end
        return n;
    endfunction

    function automatic int ref_mask(input logic [FRAME_W-1:0] f);
        logic [FRAME_W-1:0] m;
        logic [FRAME_W-1:0] sh;
        m = '0;
        for (int i = 3; i < FRAME_W; i++) begin
            sh = f >> (FRAME_W - 1 - i);
            if (sh[3:0] == 4'b1011) m[FRAME_W-1-i] = 1'b1;
        end
        return int'(m);
    endfunction

    // Monitor and reference model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [N_REQ-1:0]   exp_g;
        logic [FRAME_W-1:0] f;
        int                 sel, j, exp_din;
        exp_t               e;
        if (!rstn) begin
            check("det_rstn_in_reset", int'(det_rstn), 0);
            check("det_din_in_reset", int'(det_din), 0);
            check("gnt_in_reset", int'(gnt), 0);
            sb.delete();
            rr_m = 0;
            next_free = cyc + 1;
            last_g = -100;
            gnt_seen = '0;
        end else begin
            check("busy", int'(busy), int'(cyc < next_free));
            check("det_rstn", int'(det_rstn), int'(cyc != last_g + 1));
            exp_din = 0;
            if (cyc >= last_g + 2 && cyc <= last_g + 1 + FRAME_W)
                exp_din = int'(cur_f[FRAME_W - 1 - (cyc - last_g - 2)]);
            check("det_din", int'(det_din), exp_din);
            check("gnt_done_excl", int'(gnt != '0 && done), 0);

            exp_g = '0;
            sel = -1;
            if (cyc >= next_free) begin
                for (int k = 0; k < N_REQ; k++) begin
                    j = (rr_m + k) % N_REQ;
                    if (sel < 0 && req[j]) sel = j;
                end
            end
            if (sel >= 0) exp_g[sel] = 1'b1;
            check("gnt", int'(gnt), int'(exp_g));
            if (sel >= 0) begin
                f = frame_data[sel*FRAME_W +: FRAME_W];
                e.id = sel; e.cnt = ref_count(f); e.mask = ref_mask(f); e.due = cyc + FRAME_W + 2;
                sb.push_back(e);
                rr_m = (sel + 1) % N_REQ;
                next_free = cyc + FRAME_W + 3;
                last_g = cyc;
                cur_f = f;
                gnt_log.push_back(sel);
                gnt_cyc_log.push_back(cyc);
            end
            gnt_seen = gnt;

            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_id", int'(done_id), e.id);
                    check("hit_count", int'(hit_count), e.cnt);
`ifdef SEQ_DET_HIT_MASK_EN
                    check("hit_mask", int'(hit_mask), e.mask);
`endif
                    check("done_cycle", cyc, e.due);
                end
                e.id = int'(done_id); e.cnt = int'(hit_count); e.due = cyc;
`ifdef SEQ_DET_HIT_MASK_EN
                e.mask = int'(hit_mask);
`else
                e.mask = 0;
`endif
                done_log.push_back(e);
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                check("missing_done", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    // Requesters: hold req/frame until granted, then move to the next queued word.
    initial begin
        for (int i = 0; i < N_REQ; i++) begin head[i] = 0; tail[i] = 0; end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_seen[i] && head[i] != tail[i]) head[i]++;
                req[i] = (head[i] != tail[i]);
                frame_data[i*FRAME_W +: FRAME_W] = (head[i] != tail[i]) ? pend[i][head[i] % QD] : '0;
            end
        end
    end

    task automatic enqueue(input int id, input logic [FRAME_W-1:0] f);
        pend[id][tail[id] % QD] = f;
        tail[id]++;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N_REQ; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int t;
        t = 0;
        @(posedge clk); #2;
        while ((!all_empty() || sb.size() > 0 || busy) && t < 5000) begin
            @(posedge clk); #2;
            t++;
        end
        check("wait_idle_timeout", int'(t >= 5000), 0);
    endtask

    task automatic wait_grant();
        int n, t;
        n = gnt_log.size();
        t = 0;
        while (gnt_log.size() == n && t < 200) begin
            @(posedge clk); t++;
        end
        check("wait_grant_timeout", int'(t >= 200), 0);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    initial begin
        int g, nd;
        logic [FRAME_W-1:0] f;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        check("reset_done", int'(done), 0);
        check("reset_hit_count", int'(hit_count), 0);
        check("reset_done_id", int'(done_id), 0);
        check("reset_busy", int'(busy), 0);

        // Single request, known frame
        enqueue(0, 16'hB6D0);
        wait_idle();
        check("t1_id", done_log[$].id, 0);
        check("t1_count", done_log[$].cnt, 3);
`ifdef SEQ_DET_HIT_MASK_EN
        check("t1_mask", done_log[$].mask, 32'h1240);
`endif
        check("t1_latency", done_log[$].due - gnt_cyc_log[$], FRAME_W + 2);

        // Cross-frame isolation: 0101 followed by a leading 1 must not hit
        enqueue(1, 16'h0005);
        enqueue(1, 16'h8000);
        wait_idle();
        check("t2_count_a", done_log[done_log.size()-2].cnt, 0);
        check("t2_count_b", done_log[$].cnt, 0);

        // After a grant to 1, requests from 1 and 3 -> 3 then 1
        do_reset();
        enqueue(1, 16'($urandom));
        wait_grant();
        enqueue(1, 16'($urandom));
        enqueue(3, 16'($urandom));
        wait_idle();
        check("t4_g0", gnt_log[gnt_log.size()-3], 1);
        check("t4_g1", gnt_log[gnt_log.size()-2], 3);
        check("t4_g2", gnt_log[gnt_log.size()-1], 1);

        // All four requesting continuously from rr_ptr=0
        do_reset();
        enqueue(0, 16'($urandom));
        enqueue(0, 16'($urandom));
        enqueue(1, 16'($urandom));
        enqueue(2, 16'($urandom));
        enqueue(3, 16'($urandom));
        wait_idle();
        for (int k = 0; k < 5; k++)
            check("t3_order", gnt_log[gnt_log.size()-5+k], k % N_REQ);
        for (int k = 0; k < 4; k++)
            check("t3_spacing", gnt_cyc_log[gnt_cyc_log.size()-4+k] - gnt_cyc_log[gnt_cyc_log.size()-5+k], FRAME_W + 3);

        // Reset during SHIFT of bit 7
        enqueue(2, 16'hBBBB);
        wait_grant();
        g = gnt_cyc_log[$];
        nd = done_log.size();
        while (cyc < g + 10) begin @(posedge clk); #1; end
        rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        check("t5_busy_after_reset", int'(busy), 0);
        repeat (FRAME_W + 4) @(posedge clk);
        #1;
        check("t5_no_done", done_log.size(), nd);
        enqueue(2, 16'hB6D0);
        wait_idle();
        check("t5_recover_count", done_log[$].cnt, 3);

        // Boundary frames
        enqueue(1, 16'hFFFF); wait_idle();
        check("t6_ffff", done_log[$].cnt, 0);
        enqueue(2, 16'h0000); wait_idle();
        check("t6_0000", done_log[$].cnt, 0);
        enqueue(3, 16'hBBBB); wait_idle();
        check("t6_bbbb", done_log[$].cnt, 4);
        check("t6_hold", int'(hit_count), 4);

        // Randomized traffic, biased toward hit-rich words
        for (int n = 0; n < 60; n++) begin
            f = 16'($urandom);
            if ($urandom_range(0, 2) == 0) f = 16'hBBBB ^ (16'h1 << $urandom_range(0, 15));
            enqueue(int'($urandom_range(0, N_REQ - 1)), f);
            repeat ($urandom_range(0, 25)) @(posedge clk);
            #2;
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, expected finish before 2000000 ns");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end
endmodule
